// File: rtl/pipe_reg_w_elastic.sv
// MEM/WB pipeline register with valid/ready handshake, optional one-entry skid slot,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_reg_w_elastic #(
  parameter int unsigned   DW       = 32,
  parameter int unsigned   RW       = 5,
  parameter logic [DW-1:0] PC_RESET = DW'(32'h0000_3000),
  parameter int unsigned   SKID     = 1,
  parameter int unsigned   CNT_W    = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    IR_M,
  input  logic [RW-1:0]    A3_M,
  input  logic [DW-1:0]    PC4_M,
  input  logic [DW-1:0]    AMO_M,
  input  logic [DW-1:0]    DMOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    IR_W,
  output logic [RW-1:0]    A3_W,
  output logic [DW-1:0]    PC4_W,
  output logic [DW-1:0]    AMO_W,
  output logic [DW-1:0]    DR_W,
  output logic [CNT_W-1:0] StallCnt
);

  typedef struct packed {
    logic [DW-1:0] ir;
    logic [RW-1:0] a3;
    logic [DW-1:0] pc4;
    logic [DW-1:0] amo;
    logic [DW-1:0] dr;
  } payload_t;

  localparam payload_t PayloadRst = '{ir: '0, a3: '0, pc4: PC_RESET, amo: '0, dr: '0};
  localparam bit       HasSkid    = (SKID != 0);

  payload_t m_q, m_d, s_q, s_d, in_pay;
  logic     v_m_q, v_m_d, v_s_q, v_s_d;
  logic     in_fire, m_load;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_pay = '{ir: IR_M, a3: A3_M, pc4: PC4_M, amo: AMO_M, dr: DMOut};

  // With the skid slot, in_ready depends only on state, cutting the out_ready->in_ready path.
  assign in_ready = HasSkid ? !v_s_q : (!v_m_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign m_load   = !v_m_q || out_ready;

  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    v_m_d = v_m_q;
    v_s_d = v_s_q;
    if (Flush) begin
      m_d   = PayloadRst;
      s_d   = PayloadRst;
      v_m_d = 1'b0;
      v_s_d = 1'b0;
    end else begin
      if (m_load) begin
        if (HasSkid && v_s_q) begin
          m_d   = s_q;
          v_m_d = 1'b1;
          v_s_d = 1'b0;
        end else if (in_fire) begin
          m_d   = in_pay;
          v_m_d = 1'b1;
        end else begin
          // Bubble: nop with no register write; remaining fields hold.
          v_m_d = 1'b0;
          m_d.ir = '0;
          m_d.a3 = '0;
        end
      end
      if (HasSkid && v_m_q && !out_ready && in_fire) begin
        s_d   = in_pay;
        v_s_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v_m_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      m_q   <= PayloadRst;
      s_q   <= PayloadRst;
      v_m_q <= 1'b0;
      v_s_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      s_q   <= HasSkid ? s_d : PayloadRst;
      v_m_q <= v_m_d;
      v_s_q <= HasSkid ? v_s_d : 1'b0;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = v_m_q;
  assign IR_W      = m_q.ir;
  assign A3_W      = m_q.a3;
  assign PC4_W     = m_q.pc4;
  assign AMO_W     = m_q.amo;
  assign DR_W      = m_q.dr;
  assign StallCnt  = cnt_q;

endmodule

// File: tb/tb_pipe_reg_w_elastic.sv
// Directed bench for pipe_reg_w_elastic: per-cycle vector table on the default
// configuration plus hand sequences for counter saturation and the no-skid variant.
module tb_pipe_reg_w_elastic;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] IR_M = '0, PC4_M = '0, AMO_M = '0, DMOut = '0;
  logic [4:0]  A3_M = '0;

  logic        in_ready, out_valid;
  logic [31:0] IR_W, PC4_W, AMO_W, DR_W;
  logic [4:0]  A3_W;
  logic [15:0] StallCnt;

  logic        c4_in_ready, c4_out_valid;
  logic [31:0] c4_ir, c4_pc4, c4_amo, c4_dr;
  logic [4:0]  c4_a3;
  logic [3:0]  c4_cnt;

  logic        ns_in_ready, ns_out_valid;
  logic [31:0] ns_ir, ns_pc4, ns_amo, ns_dr;
  logic [4:0]  ns_a3;
  logic [15:0] ns_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clock = ~Clock;

  pipe_reg_w_elastic dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .in_valid(in_valid), .in_ready(in_ready),
    .IR_M(IR_M), .A3_M(A3_M), .PC4_M(PC4_M), .AMO_M(AMO_M), .DMOut(DMOut),
    .out_valid(out_valid), .out_ready(out_ready), .IR_W(IR_W), .A3_W(A3_W), .PC4_W(PC4_W),
    .AMO_W(AMO_W), .DR_W(DR_W), .StallCnt(StallCnt)
  );

  pipe_reg_w_elastic #(.CNT_W(4)) dut_c4 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .in_valid(in_valid), .in_ready(c4_in_ready),
    .IR_M(IR_M), .A3_M(A3_M), .PC4_M(PC4_M), .AMO_M(AMO_M), .DMOut(DMOut),
    .out_valid(c4_out_valid), .out_ready(out_ready), .IR_W(c4_ir), .A3_W(c4_a3),
    .PC4_W(c4_pc4), .AMO_W(c4_amo), .DR_W(c4_dr), .StallCnt(c4_cnt)
  );

  pipe_reg_w_elastic #(.SKID(0)) dut_ns (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .in_valid(in_valid), .in_ready(ns_in_ready),
    .IR_M(IR_M), .A3_M(A3_M), .PC4_M(PC4_M), .AMO_M(AMO_M), .DMOut(DMOut),
    .out_valid(ns_out_valid), .out_ready(out_ready), .IR_W(ns_ir), .A3_W(ns_a3),
    .PC4_W(ns_pc4), .AMO_W(ns_amo), .DR_W(ns_dr), .StallCnt(ns_cnt)
  );

  // Payload of entry k; k = 0 gives the reset/bubble values.
  function automatic logic [31:0] f_ir(int unsigned k);
    return (k == 0) ? 32'h0 : (32'h3C01_0000 | k);
  endfunction
  function automatic logic [31:0] f_pc4(int unsigned k);
    return 32'h0000_3000 + 4 * k;
  endfunction
  function automatic logic [31:0] f_amo(int unsigned k);
    return 32'h11 * k;
  endfunction
  function automatic logic [31:0] f_dr(int unsigned k);
    return 32'h22 * k;
  endfunction

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    int unsigned id;
    logic        ordy;
    logic        e_ov;
    logic        e_irdy;
    int unsigned e_id;   // entry whose IR/A3 are expected (0 = bubble)
    int unsigned e_hid;  // entry whose PC4/AMO/DR are expected (0 = reset values)
    int unsigned e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic flush, logic iv, int unsigned id, logic ordy,
                              logic e_ov, logic e_irdy, int unsigned e_id,
                              int unsigned e_hid, int unsigned e_cnt);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = e_ov; v.e_irdy = e_irdy; v.e_id = e_id; v.e_hid = e_hid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic iv, int unsigned id, logic ordy);
    in_valid  = iv;
    IR_M      = f_ir(id);
    A3_M      = 5'(id);
    PC4_M     = f_pc4(id);
    AMO_M     = f_amo(id);
    DMOut     = f_dr(id);
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // rst flush iv id ordy | ov irdy id hid cnt
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0));  // reset
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0));  // idle
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 0));  // stream 0x3004
    vecs.push_back(mk(0, 0, 1, 2, 1, 1, 1, 2, 2, 0));  // stream 0x3008
    vecs.push_back(mk(0, 0, 1, 3, 1, 1, 1, 3, 3, 0));  // stream 0x300C
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3, 0));  // bubble, payload holds
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 1, 1, 0));  // drain: single entry
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 4, 1, 1, 1, 4, 4, 0));  // A
    vecs.push_back(mk(0, 0, 1, 5, 0, 1, 0, 4, 4, 1));  // B into skid
    vecs.push_back(mk(0, 0, 1, 6, 0, 1, 0, 4, 4, 2));  // C held upstream
    vecs.push_back(mk(0, 0, 1, 6, 0, 1, 0, 4, 4, 3));
    vecs.push_back(mk(0, 0, 1, 6, 1, 1, 1, 5, 5, 3));  // release: B from skid
    vecs.push_back(mk(0, 0, 1, 6, 1, 1, 1, 6, 6, 3));  // C accepted
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 6, 3));
    vecs.push_back(mk(0, 0, 1, 7, 0, 1, 1, 7, 7, 3));  // fill main
    vecs.push_back(mk(0, 0, 1, 8, 0, 1, 0, 7, 7, 4));  // fill skid
    vecs.push_back(mk(0, 1, 1, 9, 0, 0, 1, 0, 0, 5));  // flush with both full
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5));  // empty: no stall count
    vecs.push_back(mk(0, 1, 1, 10, 1, 0, 1, 0, 0, 5)); // flush drops accepted input
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));  // reset clears counter

    drive(0, 0, 1);
    step();
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      Reset = vecs[i].rst;
      Flush = vecs[i].flush;
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy);
      step();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
      chk($sformatf("v%0d IR_W", i), IR_W, f_ir(vecs[i].e_id));
      chk($sformatf("v%0d A3_W", i), 32'(A3_W), vecs[i].e_id);
      chk($sformatf("v%0d PC4_W", i), PC4_W, f_pc4(vecs[i].e_hid));
      chk($sformatf("v%0d AMO_W", i), AMO_W, f_amo(vecs[i].e_hid));
      chk($sformatf("v%0d DR_W", i), DR_W, f_dr(vecs[i].e_hid));
      chk($sformatf("v%0d StallCnt", i), 32'(StallCnt), vecs[i].e_cnt);
    end
    Reset = 1'b0;
    Flush = 1'b0;

    // Saturation: 4-bit counter stops at 15, 16-bit keeps counting.
    Reset = 1'b1;
    drive(0, 0, 1);
    step();
    Reset = 1'b0;
    drive(1, 1, 0);
    step();
    chk("sat c4 out_valid", 32'(c4_out_valid), 32'd1);
    drive(0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat c4 cnt %0d", i), 32'(c4_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    chk("sat wide cnt", 32'(StallCnt), 32'd20);

    // No-skid variant: in_ready follows out_ready while the main slot is full.
    Reset = 1'b1;
    drive(0, 0, 1);
    step();
    Reset = 1'b0;
    drive(1, 4, 1);
    step();
    chk("ns A accepted", ns_ir, f_ir(4));
    drive(1, 5, 0);
    #1;
    chk("ns full stall in_ready", 32'(ns_in_ready), 32'd0);
    step();
    chk("ns A held", ns_ir, f_ir(4));
    chk("ns stall cnt", ns_cnt, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("ns full release in_ready", 32'(ns_in_ready), 32'd1);
    step();
    chk("ns B follows", ns_ir, f_ir(5));
    chk("ns B valid", 32'(ns_out_valid), 32'd1);
    drive(0, 0, 1);
    step();
    chk("ns bubble ir", ns_ir, 32'd0);
    chk("ns bubble pc4 holds", ns_pc4, f_pc4(5));
    out_ready = 1'b0;
    #1;
    chk("ns empty in_ready", 32'(ns_in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg_w_elastic.md
Name: pipe_reg_w_elastic

Overview:
Parametrised MEM/WB pipeline register carrying IR, A3, PC4, AMO and DR into the writeback stage. It adds a valid/ready handshake, an optional one-entry skid buffer, flush-to-bubble and a saturating stall-cycle counter, so stage-boundary registers can stall and flush without external glue. It sits between the memory stage and the writeback/GRF stage and replaces the fixed always-load W register.

Parameters:
DW, 32, width of IR, PC4, AMO and DR fields
RW, 5, width of A3 (destination register index)
PC_RESET, 32'h0000_3000, reset and flush value of PC4
SKID, 1, 1 = two-entry elastic buffer (registered in_ready); 0 = single register (combinational in_ready)
CNT_W, 16, stall counter width

Ports:
Clock  in  1  clock, all state updates on posedge
Reset  in  1  synchronous, active-high
Flush  in  1  discard all held and incoming entries this cycle
in_valid  in  1  M-stage entry present
in_ready  out  1  entry accepted when in_valid & in_ready
IR_M  in  DW  instruction
A3_M  in  RW  destination register
PC4_M  in  DW  PC+4
AMO_M  in  DW  ALU/MDU result
DMOut  in  DW  data-memory read data
out_valid  out  1  W-stage entry valid
out_ready  in  1  W stage consumes when out_valid & out_ready
IR_W, A3_W, PC4_W, AMO_W, DR_W  out  DW/RW/DW/DW/DW  registered payload of main slot
StallCnt  out  CNT_W  cycles with out_valid & !out_ready

Behaviour:
- State: main slot M (payload + v_m), skid slot S (payload + v_s, present only when SKID=1). Outputs driven directly from M registers; out_valid = v_m.
- Reset (sync, priority over everything): v_m=v_s=0; IR_W=0, A3_W=0, PC4_W=PC_RESET, AMO_W=0, DR_W=0; S payload same values; StallCnt=0.
- Flush (when not Reset): v_m=v_s=0; M and S payload take reset values; any same-cycle input handshake is dropped (no entry enters). StallCnt unaffected.
- in_ready: SKID=1 -> in_ready = !v_s (registered, no combinational path from out_ready). SKID=0 -> in_ready = !v_m | out_ready.
- in_fire = in_valid & in_ready; out_fire = v_m & out_ready. Latency: 1 cycle input-to-output when unstalled; full throughput of 1 entry/cycle.
- M update (no Reset/Flush): if !v_m or out_fire: if v_s, M<=S, v_s<=0; else if in_fire, M<=input, v_m<=1; else v_m<=0 and IR_W<=0, A3_W<=0 (bubble: nop, no GRF write), PC4_W/AMO_W/DR_W hold.
- S update (SKID=1): if v_m & !out_ready & in_fire, S<=input, v_s<=1. S is never written while v_s=1 (guaranteed by in_ready).
- Order preserved: entries leave in acceptance order; no duplication, no loss except on Flush.
- in_valid with in_ready=0: input ignored, upstream must hold.
- StallCnt: +1 each cycle with v_m & !out_ready, saturates at all-ones, cleared only by Reset.
- SKID=0: S logic and v_s absent; identical M rules otherwise.

Test Plan:
- Reset then idle: IR_W=0, A3_W=0, PC4_W=32'h0000_3000, out_valid=0, in_ready=1, StallCnt=0.
- Streaming, out_ready=1: inputs PC4_M=0x3004,0x3008,0x300C back-to-back -> PC4_W same sequence 1 cycle later, out_valid stays 1, StallCnt=0.
- Backpressure SKID=1: out_ready=0 from cycle 2 while sending A,B,C -> A held on outputs, B in skid, in_ready=0, C held upstream; release out_ready -> A,B,C out in order, StallCnt equals stalled cycles.
- Flush with v_m=v_s=1 and in_valid=1: next cycle out_valid=0, IR_W=0, A3_W=0, PC4_W=0x3000; the incoming entry never appears.
- Drain: single entry IR_M=0x3C01_0001, A3_M=1, then in_valid=0 -> one valid cycle, then IR_W=0, A3_W=0, out_valid=0.
- CNT_W=4, out_ready=0 for 20 cycles with v_m=1 -> StallCnt stops at 15; SKID=0 rerun of scenario 3 shows in_ready = out_ready when full.
